// File: rtl/instr_mem_loader.sv
// Byte-stream loader for the instruction memory: packs little-endian bytes into 32-bit words.
// Define LOADER_CHECKSUM_EN to add a modulo-256 byte checksum (csum_o) checked against exp_csum_i.
module instr_mem_loader #(
  parameter int unsigned W     = 32,
  parameter int unsigned D     = 2000,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [31:0]      base_addr_i,
  input  logic [CNT_W-1:0] num_words_i,
  input  logic             s_valid_i,
  input  logic [7:0]       s_data_i,
`ifdef LOADER_CHECKSUM_EN
  input  logic [7:0]       exp_csum_i,
  output logic [7:0]       csum_o,
`endif
  output logic             s_ready_o,
  output logic             mem_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [W-1:0]     mem_wdata_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int unsigned SumW = CNT_W + 30;

  typedef enum logic [1:0] {StIdle, StLoad, StWrite, StDone} state_e;

  state_e           state_q, state_d;
  logic [31:0]      base_q, base_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [23:0]      word_q, word_d;
  logic [31:0]      addr_q, addr_d;
  logic [W-1:0]     wdata_q, wdata_d;
  logic             err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
  logic [7:0]       exp_q, exp_d;
`endif

  logic [SumW-1:0]  end_idx;
  logic             range_bad;
  logic             accept;

  // base index + count compared against D+1 avoids the wrap that "- 1" would cause at count 0
  assign end_idx   = SumW'(base_addr_i[30:2]) + SumW'(num_words_i);
  assign range_bad = (base_addr_i[1:0] != 2'b00) || base_addr_i[31] || (end_idx > SumW'(D + 1));
  assign accept    = (state_q == StLoad) && s_valid_i;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    word_d  = word_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
    exp_d   = exp_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          base_d = base_addr_i;
          num_d  = num_words_i;
          cnt_d  = '0;
          idx_d  = '0;
          err_d  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          csum_d = '0;
          exp_d  = exp_csum_i;
`endif
          if (range_bad) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else if (num_words_i == '0) begin
`ifdef LOADER_CHECKSUM_EN
            err_d   = (exp_csum_i != 8'h00);
`endif
            state_d = StDone;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        if (accept) begin
          idx_d = idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q + s_data_i;
`endif
          unique case (idx_q)
            2'd0: word_d[7:0]   = s_data_i;
            2'd1: word_d[15:8]  = s_data_i;
            2'd2: word_d[23:16] = s_data_i;
            2'd3: begin
              wdata_d = W'({s_data_i, word_q});
              addr_d  = base_q + 32'({cnt_q, 2'b00});
              state_d = StWrite;
            end
            default: ;
          endcase
        end
      end
      StWrite: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_d == num_q) begin
`ifdef LOADER_CHECKSUM_EN
          if (csum_q != exp_q) err_d = 1'b1;
`endif
          state_d = StDone;
        end else begin
          state_d = StLoad;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      base_q  <= '0;
      num_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= '0;
      exp_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
      exp_q   <= exp_d;
`endif
    end
  end

  assign s_ready_o   = (state_q == StLoad);
  assign mem_we_o    = (state_q == StWrite);
  assign busy_o      = (state_q == StLoad) || (state_q == StWrite);
  assign done_o      = (state_q == StDone);
  assign err_o       = err_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
`ifdef LOADER_CHECKSUM_EN
  assign csum_o      = csum_q;
`endif

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Writer-side counterpart of the read-only instruction memory: fills the instruction store at run time from a byte stream (boot/debug link) instead of a build-time image.
- Assembles incoming bytes into 32-bit little-endian words and issues one write per word on the memory write port.
- Writes go to consecutive word-aligned byte addresses, starting at a programmed base.
- Sits between the host byte link and the instruction memory write port; the core is held off while busy is high.

Parameters:
- W, 32, memory word width; fixed at 32, 4 bytes per word.
- D, 2000, highest valid word index of the instruction memory; valid indices are 0..D.
- CNT_W, 16, width of the word-count input and internal word counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle load request; sampled only in IDLE.
- base_addr  input  32  byte address of the first word; latched on start.
- num_words  input  CNT_W  number of words to load; latched on start.
- s_valid  input  1  byte-stream valid.
- s_data  input  8  byte-stream data.
- s_ready  output  1  byte accepted when s_valid and s_ready are both high.
- mem_we  output  1  one-cycle write strobe to the instruction memory.
- mem_addr  output  32  byte address of the write; bits [1:0] always 0.
- mem_wdata  output  32  assembled word.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse at the end of a load, including error aborts.
- err  output  1  sticky range/alignment error; cleared by the next accepted start.

Behaviour:
- Reset: state IDLE; s_ready, mem_we, busy, done, err all 0; mem_addr, mem_wdata, byte index and word counter all 0. Reset is asynchronous and aborts any load mid-operation. Partially assembled words are discarded and never written.
- Word index: the write for word k goes to byte address base + 4*k. The memory decodes this as {3'b000, addr[30:2]}.
- States:
  - IDLE: s_ready=0. On start:
    - Latch base_addr and num_words; clear err.
    - If base_addr[1:0]!=0, base_addr[31]=1, or base_addr[30:2] + num_words - 1 > D (computed CNT_W+30 bits wide, no wrap): set err and go to DONE.
    - Else if num_words==0: go to DONE.
    - Else: go to LOAD.
  - LOAD: s_ready=1. Each accepted byte goes to lane byte_idx; the first byte lands in [7:0], the fourth in [31:24]. byte_idx increments mod 4. Acceptance of the 4th byte moves to WRITE.
  - WRITE: exactly one cycle; s_ready=0; mem_we=1 with mem_addr and mem_wdata stable. The word counter then increments. If the counter equals num_words, go to DONE; else go to LOAD.
  - DONE: done=1 for one cycle, busy=0, return to IDLE.
- Latency:
  - Minimum 5 cycles per word: 4 accept cycles plus 1 write cycle.
  - done asserts 1 cycle after the final write.
  - Error abort: done asserts 1 cycle after start.
- mem_we is never high outside WRITE. mem_addr and mem_wdata hold their last values when mem_we is low.
- start asserted while busy is ignored. s_valid while s_ready=0 is not consumed; the source must hold the byte.
- Stream stalls (s_valid low) of any length are tolerated; no timeout.
- The word counter never wraps: the range check guarantees the final index is at most D.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined:
  - Adds output csum[7:0], an 8-bit modulo-256 sum of every accepted byte. It is cleared on accepted start and is valid when done pulses.
  - Adds input exp_csum[7:0], latched on start. If csum != exp_csum at completion, err is set in the same cycle done pulses. Writes already issued are not undone.
- Undefined: no csum or exp_csum ports; err reflects range/alignment only.

Test Plan:
- Base 0x00000000, num_words=2, bytes 11 22 33 44 55 66 77 88 with s_valid always high -> mem_we at 0x0 with 0x44332211, then at 0x4 with 0x88776655. done pulses once, err=0, total 11 cycles from start.
- Base 0x00000010, num_words=1, s_valid toggling 1/0 -> single write at 0x10. No byte lost or duplicated. s_ready low during WRITE.
- Range and alignment errors:
  - base 0x2 -> err=1, done 1 cycle after start, no mem_we.
  - base 4*D, num_words=2 -> err=1, no writes.
  - base 4*D, num_words=1 -> one write at index D, err=0.
- num_words=0 -> done pulses, no writes, err=0. A start pulse during an active load is ignored, and the active load completes unchanged.
- rst_n low after 2 bytes of word 0 -> all outputs return to reset values immediately. A fresh start then loads 0xDEADBEEF (bytes EF BE AD DE) to base correctly.
- LOADER_CHECKSUM_EN: bytes 01 02 03 04 with exp_csum=0x0A -> err=0. Same bytes with exp_csum=0x0B -> write still issued, err=1 with done.
